// File: rtl/addr8u_ctrl_pkg.sv
// addr8u_ctrl_pkg: shared state encoding and datapath widths for the addr8u sharing controller
package addr8u_ctrl_pkg;
  localparam int OPW = 8;
  localparam int RESW = 9;
  typedef enum logic [1:0] {IDLE, ISSUE, CHECK, RESP} state_t;
endpackage

// File: rtl/addr8u_rr_arbiter.sv
// addr8u_rr_arbiter: combinational round-robin grant with a pointer that advances past each accepted requester
module addr8u_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] valid,
  input  logic            accept,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  gid
);
  logic [IDW-1:0] ptr;
  logic found;
  int idx;
  // first valid requester at or after the pointer, wrapping at NREQ
  always_comb begin
    grant = '0;
    gid = '0;
    found = 1'b0;
    idx = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(ptr) + i;
      idx = (idx >= NREQ) ? idx - NREQ : idx;
      if (!found && valid[idx]) begin
        found = 1'b1;
        grant[idx] = 1'b1;
        gid = IDW'(idx);
      end
    end
  end
  // pointer moves to the requester after the one just served
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= '0;
    else if (accept) ptr <= (gid == IDW'(NREQ - 1)) ? '0 : gid + IDW'(1);
endmodule

// File: rtl/addr8u_share_ctrl.sv
// addr8u_share_ctrl: time-shares one external 8-bit adder among NREQ requesters (optional ADDR_RECHECK_EN swapped-operand recheck)
module addr8u_share_ctrl
  import addr8u_ctrl_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req_valid,
  output logic [NREQ-1:0]  req_ready,
  input  logic [NREQ*8-1:0] req_a,
  input  logic [NREQ*8-1:0] req_b,
  output logic [7:0]       add_a,
  output logic [7:0]       add_b,
  input  logic [8:0]       add_sum,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [8:0]       rsp_sum,
  output logic [IDW-1:0]   rsp_id,
  output logic             rsp_err
`ifdef ADDR_RECHECK_EN
  ,
  output logic [7:0]       err_cnt
`endif
);
  state_t state, state_d;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0] gid, cap_id;
  logic [OPW-1:0] cap_a, cap_b;
  logic accept;
`ifdef ADDR_RECHECK_EN
  localparam state_t AFTER_ISSUE = CHECK;
`else
  localparam state_t AFTER_ISSUE = RESP;
`endif
  assign req_ready = (rst_n && state == IDLE) ? grant : '0;
  assign accept = |(req_valid & req_ready);
  assign rsp_valid = state == RESP;
  assign add_a = (state == ISSUE) ? cap_a : (state == CHECK) ? cap_b : '0;
  assign add_b = (state == ISSUE) ? cap_b : (state == CHECK) ? cap_a : '0;
  addr8u_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .clk(clk),
    .rst_n(rst_n),
    .valid(req_valid),
    .accept(accept),
    .grant(grant),
    .gid(gid)
  );
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  // next-state: accept, issue, optional check, hold response until taken
  always_comb begin
    state_d = IDLE;
    state_d = (state == IDLE) ? (accept ? ISSUE : IDLE) :
              (state == ISSUE) ? AFTER_ISSUE :
              (state == CHECK) ? RESP :
              (state == RESP && !rsp_ready) ? RESP : IDLE;
  end
  // capture operands on accept, register the issue-cycle sum as the response
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cap_a <= '0;
      cap_b <= '0;
      cap_id <= '0;
      rsp_sum <= '0;
      rsp_id <= '0;
    end else begin
      if (accept) begin
        cap_a <= req_a[OPW*gid +: OPW];
        cap_b <= req_b[OPW*gid +: OPW];
        cap_id <= gid;
      end
      if (state == ISSUE) begin
        rsp_sum <= add_sum;
        rsp_id <= cap_id;
      end
    end
`ifdef ADDR_RECHECK_EN
  // swapped-operand sum must equal the issue sum; count mismatches up to saturation
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rsp_err <= 1'b0;
      err_cnt <= '0;
    end else if (state == CHECK) begin
      rsp_err <= add_sum != rsp_sum;
      err_cnt <= (add_sum != rsp_sum && err_cnt != 8'hFF) ? err_cnt + 8'd1 : err_cnt;
    end
`else
  assign rsp_err = 1'b0;
`endif
endmodule

// File: tb/tb_addr8u_share_ctrl.sv
// tb_addr8u_share_ctrl: table-driven and scoreboard checks of addr8u_share_ctrl against a behavioural adder
module tb_addr8u_share_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] req_valid, req_ready;
  logic [31:0] req_a, req_b;
  logic [7:0] add_a, add_b;
  logic [8:0] add_sum, rsp_sum;
  logic rsp_valid, rsp_ready, rsp_err;
  logic [1:0] rsp_id;
`ifdef ADDR_RECHECK_EN
  logic [7:0] err_cnt;
  logic stuck_en = 1'b0;
  logic [7:0] sw_a = '0, sw_b = '0;
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  typedef struct packed {logic [1:0] id; logic [8:0] sum; logic err;} exp_t;
  typedef struct {int id; logic [7:0] a; logic [7:0] b; logic [8:0] sum;} vec_t;
  exp_t q[$];
  vec_t tbl[7];
  int nvec = 0, nerr = 0;
  int ord[5] = '{0, 1, 2, 3, 0};
  always #5 clk = ~clk;
  always_comb begin
    add_sum = {1'b0, add_a} + {1'b0, add_b};
`ifdef ADDR_RECHECK_EN
    if (stuck_en && add_a == sw_a && add_b == sw_b) add_sum[3] = 1'b0;
`endif
  end
  addr8u_share_ctrl #(.NREQ(4), .IDW(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum), .rsp_id(rsp_id),
    .rsp_err(rsp_err)
`ifdef ADDR_RECHECK_EN
    , .err_cnt(err_cnt)
`endif
  );
  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    nvec++;
    if ($countones(req_ready) > 1) begin
      nerr++;
      $display("FAIL ready_onehot: got %b expected at most one bit at %0t", req_ready, $time);
    end
  endtask
  task automatic send(input int id, input logic [7:0] a, input logic [7:0] b, input logic [8:0] sum, input logic err);
    int n;
    req_a[id*8 +: 8] = a;
    req_b[id*8 +: 8] = b;
    req_valid[id] = 1'b1;
    #1;
    n = 0;
    while (!req_ready[id] && n < 20) begin
      step();
      n++;
    end
    chk("grant", {12'd0, req_ready}, 16'(1 << id));
    if (req_ready[id]) begin
      q.push_back({2'(id), sum, err});
      step();
    end
    req_valid[id] = 1'b0;
  endtask
  task automatic get_rsp(input int hold);
    int n;
    exp_t e;
    rsp_ready = (hold == 0);
    n = 0;
    while (!rsp_valid && n < 20) begin
      step();
      n++;
    end
    chk("latency", 16'(n), 16'(LAT));
    if (q.size() == 0) begin
      chk("scoreboard_empty", 16'd1, 16'd0);
      e = '0;
    end else e = q.pop_front();
    for (int h = 0; h < hold; h++) begin
      chk("stall_valid", {15'd0, rsp_valid}, 16'd1);
      chk("stall_req_ready", {12'd0, req_ready}, 16'd0);
      chk("stall_sum", {7'd0, rsp_sum}, {7'd0, e.sum});
      chk("stall_id", {14'd0, rsp_id}, {14'd0, e.id});
      step();
    end
    rsp_ready = 1'b1;
    chk("rsp_valid", {15'd0, rsp_valid}, 16'd1);
    chk("rsp_sum", {7'd0, rsp_sum}, {7'd0, e.sum});
    chk("rsp_id", {14'd0, rsp_id}, {14'd0, e.id});
    chk("rsp_err", {15'd0, rsp_err}, {15'd0, e.err});
    step();
    chk("rsp_done", {15'd0, rsp_valid}, 16'd0);
  endtask
  task automatic chk_reset(input string nm);
    chk({nm, "_req_ready"}, {12'd0, req_ready}, 16'd0);
    chk({nm, "_add_a"}, {8'd0, add_a}, 16'd0);
    chk({nm, "_add_b"}, {8'd0, add_b}, 16'd0);
    chk({nm, "_rsp_valid"}, {15'd0, rsp_valid}, 16'd0);
    chk({nm, "_rsp_sum"}, {7'd0, rsp_sum}, 16'd0);
    chk({nm, "_rsp_id"}, {14'd0, rsp_id}, 16'd0);
    chk({nm, "_rsp_err"}, {15'd0, rsp_err}, 16'd0);
  endtask
  initial begin
    logic [7:0] a, b;
    int n;
    tbl[0] = '{2, 8'hFF, 8'hFF, 9'h1FE};
    tbl[1] = '{3, 8'h80, 8'h80, 9'h100};
    tbl[2] = '{0, 8'h00, 8'h00, 9'h000};
    tbl[3] = '{1, 8'h01, 8'hFF, 9'h100};
    tbl[4] = '{2, 8'h7F, 8'h01, 9'h080};
    tbl[5] = '{0, 8'hAA, 8'h55, 9'h0FF};
    tbl[6] = '{3, 8'hC8, 8'h64, 9'h12C};
    rst_n = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 4'hF;
    for (int i = 0; i < 4; i++) begin
      req_a[i*8 +: 8] = 8'(8'h10 * i + 8'h07);
      req_b[i*8 +: 8] = 8'(8'h31 * i + 8'h0C);
    end
    #1;
    chk_reset("reset");
    step();
    step();
    chk_reset("reset_held");
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      n = 0;
      while (req_ready == 4'd0 && n < 20) begin
        step();
        n++;
      end
      chk("rr_order", {12'd0, req_ready}, 16'(1 << ord[k]));
      a = req_a[ord[k]*8 +: 8];
      b = req_b[ord[k]*8 +: 8];
      q.push_back({2'(ord[k]), {1'b0, a} + {1'b0, b}, 1'b0});
      step();
      get_rsp(0);
    end
    req_valid = 4'h0;
    send(1, 8'h3C, 8'h14, 9'h050, 1'b0);
    get_rsp(0);
    for (int i = 0; i < 7; i++) begin
      send(tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].sum, 1'b0);
      get_rsp(0);
    end
    send(2, 8'h12, 8'h34, 9'h046, 1'b0);
    req_a[7:0] = 8'h21;
    req_b[7:0] = 8'h43;
    req_valid[0] = 1'b1;
    get_rsp(5);
    chk("post_stall_grant", {12'd0, req_ready}, 16'd1);
    send(0, 8'h21, 8'h43, 9'h064, 1'b0);
    get_rsp(0);
    send(1, 8'h11, 8'h22, 9'h033, 1'b0);
    void'(q.pop_back());
    chk("issue_add_a", {8'd0, add_a}, 16'h11);
    chk("issue_add_b", {8'd0, add_b}, 16'h22);
    rst_n = 1'b0;
    #1;
    chk_reset("midop_reset");
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("no_rsp_after_reset", {15'd0, rsp_valid}, 16'd0);
    end
    req_a[23:16] = 8'h05;
    req_b[23:16] = 8'h06;
    req_valid = 4'b0101;
    #1;
    chk("ptr_after_reset", {12'd0, req_ready}, 16'd1);
    send(0, 8'h21, 8'h43, 9'h064, 1'b0);
    get_rsp(0);
    send(2, 8'h05, 8'h06, 9'h00B, 1'b0);
    get_rsp(0);
`ifdef ADDR_RECHECK_EN
    chk("err_cnt_clean", {8'd0, err_cnt}, 16'd0);
    sw_a = 8'h05;
    sw_b = 8'h0A;
    stuck_en = 1'b1;
    send(3, 8'h0A, 8'h05, 9'h00F, 1'b1);
    get_rsp(0);
    chk("err_cnt_one", {8'd0, err_cnt}, 16'd1);
    stuck_en = 1'b0;
    send(1, 8'h0A, 8'h05, 9'h00F, 1'b0);
    get_rsp(0);
    chk("err_cnt_hold", {8'd0, err_cnt}, 16'd1);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
